step_dir_decoder: RTL and testbench

- Step/direction receiver for the stepper ("passo a passo") datapath.
- Accepts filtered STEP pulses plus a DIR level from the dedicated inputs, and advances an 8-entry coil phase sequence (full-step or half-step).
- Maintains a signed position count and de-energizes the coils after an idle timeout.
- Decoder counterpart of the step/dir pulse generator that drives the user project pins.

---
 rtl/step_dir_decoder.sv | 186 ++++++++++++++++++
 tb/tb_step_dir_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_decoder.sv
// -----------------------------------------------------------------------------
// step_dir_decoder
//
// Step/direction receiver for the stepper datapath. STEP and DIR arrive on
// asynchronous pins, are synchronized, and STEP is pulse-width qualified before
// it advances an 8-entry coil phase sequence (full/wave step or half step).
// A signed position count tracks accepted steps, and the coils are dropped
// after an idle timeout unless hold_en keeps them energized.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on step_in / dir_in (>= 2)
//   MIN_PULSE    cycles synchronized STEP must be high to be accepted (>= 1)
//   IDLE_CYCLES  idle cycles before coil power-down when hold_en = 0 (>= 1)
//   POS_W        position counter width
//
// Ports
//   clk        clock, single domain
//   rst        synchronous active-high reset
//   ena        block enable; 0 = ignore steps, coils off
//   step_in    asynchronous STEP pin
//   dir_in     asynchronous DIR pin; 1 = forward, 0 = reverse
//   half_step  1 = half-step sequencing, 0 = full (wave) step
//   hold_en    1 = keep coils energized while idle
//   coils      registered coil drive {D,C,B,A}
//   position   registered signed step count (two's-complement wrap)
//   step_ack   one-cycle pulse per accepted step
//   glitch     one-cycle pulse when a STEP pulse is rejected as too short
// -----------------------------------------------------------------------------
module step_dir_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4,
  parameter int IDLE_CYCLES = 1000,
  parameter int POS_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             half_step,
  input  logic             hold_en,
  output logic [3:0]       coils,
  output logic [POS_W-1:0] position,
  output logic             step_ack,
  output logic             glitch
);

  localparam int CNT_W  = $clog2(MIN_PULSE + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0]  CNT_ACC  = CNT_W'(MIN_PULSE - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] step_sync_q;
  logic [SYNC_STAGES-1:0] dir_sync_q;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic [2:0]             idx_q,      idx_d;
  logic [POS_W-1:0]       position_q, position_d;
  logic [IDLE_W-1:0]      idle_q,     idle_d;
  logic [3:0]             coils_q,    coils_d;
  logic                   step_ack_q, step_ack_d;
  logic                   glitch_q,   glitch_d;

  logic s;
  logic d;
  logic accept;
  logic power_down;

  // Oldest synchronizer stage is the clean, metastability-settled level.
  assign s = step_sync_q[SYNC_STAGES-1];
  assign d = dir_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Coil phase table, idx 0..7
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] coil_of(input logic [2:0] i);
    logic [3:0] c;
    c = 4'b0000;
    case (i)
      3'd0: c = 4'b0001;
      3'd1: c = 4'b0011;
      3'd2: c = 4'b0010;
      3'd3: c = 4'b0110;
      3'd4: c = 4'b0100;
      3'd5: c = 4'b1100;
      3'd6: c = 4'b1000;
      3'd7: c = 4'b1001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Pulse-width filter. cnt saturates at MIN_PULSE so the accept condition
  // (cnt == MIN_PULSE-1 while high) can only be met once per high pulse.
  // A pulse that falls before reaching acceptance reports a glitch.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    accept   = 1'b0;
    glitch_d = 1'b0;
    if (!ena) begin
      cnt_d = '0;
    end else if (!s) begin
      cnt_d    = '0;
      glitch_d = (cnt_q != '0) && (cnt_q < CNT_MAX);
    end else begin
      if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      accept = (cnt_q == CNT_ACC);
    end
  end

  // ---------------------------------------------------------------------------
  // Phase index and position. In full-step mode the index is forced even;
  // an odd index left over from half-stepping snaps to the neighbouring even
  // index in the step direction.
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d      = idx_q;
    position_d = position_q;
    step_ack_d = accept;
    if (accept) begin
      if (half_step) begin
        idx_d = d ? (idx_q + 3'd1) : (idx_q - 3'd1);
      end else begin
        idx_d = d ? ((idx_q + 3'd2) & 3'b110) : ((idx_q - 3'd1) & 3'b110);
      end
      position_d = d ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));
    end
  end

  // ---------------------------------------------------------------------------
  // Idle timeout and coil drive. power_down looks at the next idle value so
  // an accept (which clears idle) re-energizes the coils on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (accept) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
    power_down = !hold_en && (idle_d == IDLE_MAX);
    coils_d    = (ena && !power_down) ? coil_of(idx_d) : 4'b0000;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      position_q  <= '0;
      idle_q      <= '0;
      coils_q     <= '0;
      step_ack_q  <= 1'b0;
      glitch_q    <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_in};
      dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      position_q  <= position_d;
      idle_q      <= idle_d;
      coils_q     <= coils_d;
      step_ack_q  <= step_ack_d;
      glitch_q    <= glitch_d;
    end
  end

  assign coils    = coils_q;
  assign position = position_q;
  assign step_ack = step_ack_q;
  assign glitch   = glitch_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// -----------------------------------------------------------------------------
// tb_step_dir_decoder
//
// Directed bench for step_dir_decoder with IDLE_CYCLES shortened to 20.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge. A behavioural model describes the decoder in terms of pulse run
// length, integer position and phase arithmetic, and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_step_dir_decoder;

  localparam int SYNC = 2;
  localparam int MINP = 4;
  localparam int IDLE = 20;
  localparam int PW   = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          step_in;
  logic          dir_in;
  logic          half_step;
  logic          hold_en;
  logic [3:0]    coils;
  logic [PW-1:0] position;
  logic          step_ack;
  logic          glitch;

  always #5 clk = ~clk;

  step_dir_decoder #(
    .SYNC_STAGES(SYNC),
    .MIN_PULSE  (MINP),
    .IDLE_CYCLES(IDLE),
    .POS_W      (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .step_in  (step_in),
    .dir_in   (dir_in),
    .half_step(half_step),
    .hold_en  (hold_en),
    .coils    (coils),
    .position (position),
    .step_ack (step_ack),
    .glitch   (glitch)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int         nvec   = 0;
  int         nerr   = 0;
  logic       chk_on = 1'b0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};
  logic       m_sh [SYNC];
  logic       m_dh [SYNC];
  int         m_run;
  int         m_pos;
  int         m_idx;
  int         m_idle;
  logic [3:0] m_coils;
  logic       m_ack;
  logic       m_glitch;

  always @(posedge clk) begin
    logic ms;
    logic md;
    logic acc;
    logic gl;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) begin
        m_sh[i] = 1'b0;
        m_dh[i] = 1'b0;
      end
      m_run    = 0;
      m_pos    = 0;
      m_idx    = 0;
      m_idle   = 0;
      m_coils  = 4'b0000;
      m_ack    = 1'b0;
      m_glitch = 1'b0;
    end else begin
      // Levels seen by the filter are the pin values SYNC edges earlier.
      ms = m_sh[SYNC-1];
      md = m_dh[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) begin
        m_sh[i] = m_sh[i-1];
        m_dh[i] = m_dh[i-1];
      end
      m_sh[0] = step_in;
      m_dh[0] = dir_in;

      acc = 1'b0;
      gl  = 1'b0;
      if (!ena) begin
        m_run = 0;
      end else if (ms) begin
        m_run = m_run + 1;
        acc   = (m_run == MINP);
      end else begin
        gl    = (m_run >= 1) && (m_run < MINP);
        m_run = 0;
      end

      if (acc) begin
        m_pos = md ? m_pos + 1 : m_pos - 1;
        if (half_step) m_idx = (m_idx + (md ? 1 : 7)) % 8;
        else if (md)   m_idx = ((m_idx / 2 + 1) * 2) % 8;
        else           m_idx = (((m_idx + 1) / 2 - 1) * 2 + 8) % 8;
        m_idle = 0;
      end else if (m_idle < IDLE) begin
        m_idle = m_idle + 1;
      end

      m_ack    = acc;
      m_glitch = gl;
      m_coils  = (ena && !(!hold_en && m_idle == IDLE)) ? tbl[m_idx] : 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    logic [15:0] pexp;
    logic [3:0]  e;
    #1;
    if (chk_on) begin
      pexp = m_pos[15:0];
      check("coils", 32'(coils), 32'(m_coils));
      check("position", 32'(position), 32'(pexp));
      check("step_ack", 32'(step_ack), 32'(m_ack));
      check("glitch", 32'(glitch), 32'(m_glitch));
      if (step_ack && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_coils", 32'(coils), 32'(e));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Holds STEP high for len rising edges, then watches gap more edges.
  // Reports the edge index (1 = first edge sampling STEP high) of the first
  // step_ack, and whether a glitch pulse was seen.
  task automatic pulse(input int len, input logic dir, input int gap,
                       output int ack_at, output int gl_seen);
    ack_at  = 0;
    gl_seen = 0;
    @(negedge clk);
    dir_in  = dir;
    step_in = 1'b1;
    for (int i = 1; i <= len + gap; i++) begin
      @(posedge clk);
      #1;
      if (step_ack && ack_at == 0) ack_at = i;
      if (glitch) gl_seen = 1;
      if (i == len) begin
        @(negedge clk);
        step_in = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         ack_at;
    int         gl_seen;
    logic [3:0] seq [5];
    seq = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100};

    rst       = 1'b1;
    ena       = 1'b1;
    step_in   = 1'b0;
    dir_in    = 1'b1;
    half_step = 1'b1;
    hold_en   = 1'b1;

    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_coils", 32'(coils), 32'h0);
    check("rst_position", 32'(position), 32'h0);
    check("rst_ack", 32'(step_ack), 32'h0);
    check("rst_glitch", 32'(glitch), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_ena_coils", 32'(coils), 32'h1);

    // Five forward half-steps, 10-cycle pulses
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(seq[k]);
      pulse(10, 1'b1, 6, ack_at, gl_seen);
      check("t1_latency", 32'(ack_at), 32'd6);
      check("t1_coils", 32'(coils), 32'(seq[k]));
    end
    check("t1_position", 32'(position), 32'd5);

    // Short pulse rejected, minimum pulse accepted
    pulse(2, 1'b1, 8, ack_at, gl_seen);
    check("short_no_ack", 32'(ack_at), 32'd0);
    check("short_glitch", 32'(gl_seen), 32'd1);
    check("short_position", 32'(position), 32'd5);
    check("short_coils", 32'(coils), 32'b1100);
    pulse(4, 1'b1, 8, ack_at, gl_seen);
    check("min_ack", 32'(ack_at), 32'd6);
    check("min_glitch", 32'(gl_seen), 32'd0);
    check("min_position", 32'(position), 32'd6);
    check("min_coils", 32'(coils), 32'b1000);

    // Half-step then full-step snapping, then reverse full steps
    do_reset(1);
    pulse(10, 1'b1, 6, ack_at, gl_seen);
    check("hs_coils", 32'(coils), 32'b0011);
    @(negedge clk);
    half_step = 1'b0;
    pulse(10, 1'b1, 6, ack_at, gl_seen);
    check("snap_fwd_coils", 32'(coils), 32'b0010);
    pulse(10, 1'b0, 6, ack_at, gl_seen);
    check("rev1_coils", 32'(coils), 32'b0001);
    pulse(10, 1'b0, 6, ack_at, gl_seen);
    check("rev2_coils", 32'(coils), 32'b1000);
    check("rev2_position", 32'(position), 32'h0000);

    // Position wrap both directions
    pulse(10, 1'b0, 6, ack_at, gl_seen);
    check("wrap_neg_position", 32'(position), 32'hFFFF);
    check("wrap_neg_coils", 32'(coils), 32'b0100);
    pulse(10, 1'b1, 6, ack_at, gl_seen);
    check("wrap_pos_position", 32'(position), 32'h0000);
    check("wrap_pos_coils", 32'(coils), 32'b1000);

    // Idle power-down and restore
    @(negedge clk);
    hold_en = 1'b0;
    pulse(6, 1'b1, 0, ack_at, gl_seen);
    check("idle_ack", 32'(ack_at), 32'd6);
    check("idle_step_coils", 32'(coils), 32'b0001);
    repeat (19) @(posedge clk);
    #1;
    check("idle_before_timeout", 32'(coils), 32'b0001);
    @(posedge clk);
    #1;
    check("idle_timeout_coils", 32'(coils), 32'b0000);
    repeat (5) @(posedge clk);
    pulse(6, 1'b1, 0, ack_at, gl_seen);
    check("restore_ack", 32'(ack_at), 32'd6);
    check("restore_coils", 32'(coils), 32'b0010);
    check("restore_position", 32'(position), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("restore_hold", 32'(coils), 32'b0010);

    // Reset in the middle of a pulse
    @(negedge clk);
    hold_en = 1'b1;
    dir_in  = 1'b1;
    step_in = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_coils", 32'(coils), 32'h0);
    check("midrst_position", 32'(position), 32'h0);
    check("midrst_ack", 32'(step_ack), 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    step_in = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_coils", 32'(coils), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check("postrst_position", 32'(position), 32'h0);

    // ena dropped during a pulse
    @(negedge clk);
    step_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    @(posedge clk);
    #1;
    check("ena_off_coils", 32'(coils), 32'h0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    step_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("ena_off_position", 32'(position), 32'h0);
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1;
    check("ena_on_coils", 32'(coils), 32'h1);
    repeat (4) @(posedge clk);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
